// File: rtl/rr_ring_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// rr_arb_pkg
// Shared types and constants for the four-requester round-robin arbiter.
//   arb_state_t        : arbiter FSM state (IDLE / BUSY)
//   N_REQ              : number of requesters (fixed at 4)
//   ID_W               : width of an encoded requester index
//   TIMEOUT_CYCLES_DEF : default grant tenure limit (timeout build only)
//   id2onehot()        : encoded index -> one-hot request/grant vector
// -----------------------------------------------------------------------------
package rr_arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_t;

   localparam int N_REQ              = 4;
   localparam int ID_W               = 2;
   localparam int TIMEOUT_CYCLES_DEF = 16;

   function automatic logic [N_REQ-1:0] id2onehot(input logic [ID_W-1:0] id);
      return N_REQ'(1) << id;
   endfunction

endpackage

// File: rtl/rr_ring_arbiter_if.sv
// -----------------------------------------------------------------------------
// rr_ring_arbiter_if
// Request/grant bundle between the clients and the arbiter.
//   req         : per-client request, held while the resource is needed
//   grant       : registered one-hot grant, zero when idle
//   grant_valid : OR of grant
//   grant_id    : encoded index of the owner, zero when idle
//   timeout     : one-cycle pulse when a grant is revoked by timeout
// Modports: master = client side (drives req), slave = arbiter side.
// -----------------------------------------------------------------------------
interface rr_ring_arbiter_if;
   import rr_arb_pkg::*;

   logic [N_REQ-1:0] req;
   logic [N_REQ-1:0] grant;
   logic             grant_valid;
   logic [ID_W-1:0]  grant_id;
   logic             timeout;

   modport master (
      output req,
      input  grant,
      input  grant_valid,
      input  grant_id,
      input  timeout
   );

   modport slave (
      input  req,
      output grant,
      output grant_valid,
      output grant_id,
      output timeout
   );

endinterface

// File: rtl/rr_ring_arbiter_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational rotating priority search.
//   mask  : candidate requesters
//   start : index searched first; order is start, start+1, ... mod N_REQ
//   found : at least one mask bit set
//   idx   : first set bit in rotated order (start when nothing found)
// -----------------------------------------------------------------------------
module rr_pick
   import rr_arb_pkg::*;
(
   input  logic [N_REQ-1:0] mask,
   input  logic [ID_W-1:0]  start,
   output logic             found,
   output logic [ID_W-1:0]  idx
);

   logic [ID_W-1:0] cand;

   // Walk the offsets from farthest to nearest so the nearest hit wins.
   always_comb begin
      found = 1'b0;
      idx   = start;
      cand  = start;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         cand = start + ID_W'(i);
         if (mask[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/rr_ring_arbiter.sv
// -----------------------------------------------------------------------------
// rr_ring_arbiter
// Four-requester round-robin arbiter for one shared downstream resource.
// A 2-bit priority pointer moves to owner+1 on every release, so each client
// is served in turn. Grant and id are registered; hand-over between owners
// happens on a single edge with no idle cycle.
//
// Ports:
//   clk  : clock, rising edge
//   rstn : asynchronous active-low reset
//   bus  : rr_ring_arbiter_if.slave (req in; grant/grant_valid/grant_id/timeout out)
//
// Parameter:
//   TIMEOUT_CYCLES : max grant tenure (2..255), only used with RR_ARB_TIMEOUT_EN
//
// Build option RR_ARB_TIMEOUT_EN: adds an 8-bit tenure counter. When a grant
// has lasted TIMEOUT_CYCLES cycles the owner is forcibly released, timeout
// pulses, and that client stays ineligible until it drops and re-raises req.
// Without the macro tenure is unbounded and timeout is tied low.
// -----------------------------------------------------------------------------
module rr_ring_arbiter
   import rr_arb_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic               clk,
   input  logic               rstn,
   rr_ring_arbiter_if.slave   bus
);

   if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
      $error("rr_ring_arbiter: TIMEOUT_CYCLES out of range 2..255");
   end

   arb_state_t       state_q, state_d;
   logic [ID_W-1:0]  ptr_q,   ptr_d;
   logic [N_REQ-1:0] grant_q, grant_d;
   logic [ID_W-1:0]  id_q,    id_d;

   logic             owner_req;
   logic             tmo_hit;
   logic             rel;
   logic [N_REQ-1:0] blocked;
   logic [N_REQ-1:0] eligible;
   logic [N_REQ-1:0] pick_mask;
   logic [ID_W-1:0]  pick_start;
   logic             pick_found;
   logic [ID_W-1:0]  pick_idx;

`ifdef RR_ARB_TIMEOUT_EN
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

   logic [7:0]       cnt_q,     cnt_d;
   logic             timeout_q, timeout_d;
   logic [N_REQ-1:0] blocked_q, blocked_d;

   assign tmo_hit = (state_q == BUSY) && bus.req[id_q] && (cnt_q == TMO_LAST);
   assign blocked = blocked_q;
`else
   assign tmo_hit = 1'b0;
   assign blocked = '0;
`endif

   // A release is the owner dropping req, or a timeout treated the same way.
   // On release the old owner is masked out of the search and the search
   // starts just past it, which is also the new pointer value.
   always_comb begin
      owner_req  = bus.req[id_q];
      rel        = (state_q == BUSY) && (!owner_req || tmo_hit);
      eligible   = bus.req & ~blocked;
      pick_mask  = eligible;
      pick_start = ptr_q;
      if (rel) begin
         pick_mask  = eligible & ~id2onehot(id_q);
         pick_start = id_q + ID_W'(1);
      end
   end

   rr_pick u_pick (
      .mask  (pick_mask),
      .start (pick_start),
      .found (pick_found),
      .idx   (pick_idx)
   );

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      grant_d = grant_q;
      id_d    = id_q;
      case (state_q)
         IDLE: begin
            if (pick_found) begin
               state_d = BUSY;
               grant_d = id2onehot(pick_idx);
               id_d    = pick_idx;
            end
         end
         BUSY: begin
            if (rel) begin
               ptr_d = id_q + ID_W'(1);
               if (pick_found) begin
                  grant_d = id2onehot(pick_idx);
                  id_d    = pick_idx;
               end else begin
                  state_d = IDLE;
                  grant_d = '0;
                  id_d    = '0;
               end
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
            id_d    = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         grant_q <= '0;
         id_q    <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
         id_q    <= id_d;
      end
   end

`ifdef RR_ARB_TIMEOUT_EN
   // Tenure counter restarts on every new owner (and sits at zero while idle).
   // A revoked client stays blocked until it is seen with req low.
   always_comb begin
      cnt_d     = cnt_q + 8'd1;
      timeout_d = tmo_hit;
      blocked_d = blocked_q & bus.req;
      if (tmo_hit) begin
         blocked_d = blocked_d | id2onehot(id_q);
      end
      if (state_q == IDLE || rel) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt_q     <= '0;
         timeout_q <= 1'b0;
         blocked_q <= '0;
      end else begin
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
         blocked_q <= blocked_d;
      end
   end

   assign bus.timeout = timeout_q;
`else
   assign bus.timeout = 1'b0;
`endif

   assign bus.grant       = grant_q;
   assign bus.grant_valid = |grant_q;
   assign bus.grant_id    = id_q;

endmodule

// File: tb/tb_rr_ring_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rr_ring_arbiter
// Directed bench for rr_ring_arbiter. The stimulus process queues the output
// change it expects (with the cycle it should appear in); a negedge monitor
// pops an entry every time the outputs change and also checks one-hot/id
// consistency every cycle. The timeout scenario is built when
// RR_ARB_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
module tb_rr_ring_arbiter;
   import rr_arb_pkg::*;

   typedef struct {
      int         cyc;
      logic [3:0] g;
      logic [1:0] id;
      logic       v;
      logic       to;
   } exp_t;

   logic clk;
   logic rstn;
   int   cyc;
   int   n_chk;
   int   n_fail;
   bit   mon_en;
   exp_t q[$];

   rr_ring_arbiter_if bus ();

   rr_ring_arbiter #(.TIMEOUT_CYCLES(4)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [3:0] g, input logic [1:0] id, input logic to, input int dc);
      exp_t e;
      e.cyc = cyc + dc;
      e.g   = g;
      e.id  = id;
      e.v   = |g;
      e.to  = to;
      q.push_back(e);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
      n_chk++;
      if (act !== req_v) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req_v);
      end
   endtask

   // ---------------- monitor ----------------
   logic [7:0] prev_snap;
   logic [7:0] cur_snap;
   logic [1:0] enc_id;
   exp_t       e_m;

   always @(negedge clk) begin
      cur_snap = {bus.timeout, bus.grant_valid, bus.grant_id, bus.grant};
      if (!mon_en) begin
         prev_snap = cur_snap;
      end else begin
         enc_id = 2'd0;
         for (int i = 0; i < 4; i++) if (bus.grant[i]) enc_id = 2'(i);
         n_chk++;
         if (!$onehot0(bus.grant) || bus.grant_id !== enc_id ||
             bus.grant_valid !== (|bus.grant)) begin
            n_fail++;
            $display("FAIL onehot_id @cyc %0d: grant=%b id=%0d valid=%b", cyc,
                     bus.grant, bus.grant_id, bus.grant_valid);
         end
         if (cur_snap !== prev_snap) begin
            n_chk++;
            if (q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_change @cyc %0d: grant=%b id=%0d to=%b", cyc,
                        bus.grant, bus.grant_id, bus.timeout);
            end else begin
               e_m = q.pop_front();
               if (e_m.cyc != cyc || e_m.g !== bus.grant || e_m.id !== bus.grant_id ||
                   e_m.v !== bus.grant_valid || e_m.to !== bus.timeout) begin
                  n_fail++;
                  $display("FAIL grant_event: got cyc=%0d grant=%b id=%0d v=%b to=%b, expected cyc=%0d grant=%b id=%0d v=%b to=%b",
                           cyc, bus.grant, bus.grant_id, bus.grant_valid, bus.timeout,
                           e_m.cyc, e_m.g, e_m.id, e_m.v, e_m.to);
               end
            end
         end
         prev_snap = cur_snap;
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      n_chk   = 0;
      n_fail  = 0;
      mon_en  = 1'b0;
      rstn    = 1'b0;
      bus.req = 4'b0000;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_grant",   32'(bus.grant),       32'h0);
      chk("reset_valid",   32'(bus.grant_valid), 32'h0);
      chk("reset_id",      32'(bus.grant_id),    32'h0);
      chk("reset_timeout", 32'(bus.timeout),     32'h0);
      rstn   = 1'b1;
      mon_en = 1'b1;
      tick();

      // first grant from idle, then direct hand-over 0 -> 2 (ptr becomes 1)
      bus.req = 4'b0101; push(4'b0001, 2'd0, 1'b0, 1); tick(); tick();
      bus.req = 4'b0100; push(4'b0100, 2'd2, 1'b0, 1); tick(); tick();

      // owner 2 releases with nobody waiting -> idle; ptr 3 wraps to find 0
      bus.req = 4'b0000; push(4'b0000, 2'd0, 1'b0, 1); tick(); tick();
      bus.req = 4'b0001; push(4'b0001, 2'd0, 1'b0, 1); tick(); tick();

      // all requesting, each owner drops for one cycle: order 0,1,2,3,0
      bus.req = 4'b1111; tick(); tick();
      bus.req = 4'b1110; push(4'b0010, 2'd1, 1'b0, 1); tick();
      bus.req = 4'b1101; push(4'b0100, 2'd2, 1'b0, 1); tick();
      bus.req = 4'b1011; push(4'b1000, 2'd3, 1'b0, 1); tick();
      bus.req = 4'b0111; push(4'b0001, 2'd0, 1'b0, 1); tick();
      bus.req = 4'b1111; tick(); tick();

      // async reset mid-tenure of owner 2
      bus.req = 4'b1110; push(4'b0010, 2'd1, 1'b0, 1); tick();
      bus.req = 4'b1101; push(4'b0100, 2'd2, 1'b0, 1); tick(); tick();
      #2;
      rstn = 1'b0;
      push(4'b0000, 2'd0, 1'b0, 0);
      #1;
      chk("async_rst_grant", 32'(bus.grant),       32'h0);
      chk("async_rst_valid", 32'(bus.grant_valid), 32'h0);
      tick();
      rstn = 1'b1;
      bus.req = 4'b1100; push(4'b0100, 2'd2, 1'b0, 1); tick(); tick();

      // owner 2 leaves, 3 takes over (ptr 3); reset again, ptr must restart at 0
      bus.req = 4'b1000; push(4'b1000, 2'd3, 1'b0, 1); tick(); tick();
      #2;
      rstn = 1'b0;
      push(4'b0000, 2'd0, 1'b0, 0);
      tick();
      rstn = 1'b1;
      bus.req = 4'b1010; push(4'b0010, 2'd1, 1'b0, 1); tick(); tick();
      bus.req = 4'b0000; push(4'b0000, 2'd0, 1'b0, 1); tick(); tick();

`ifdef RR_ARB_TIMEOUT_EN
      // clean pointer, then client 1 and 3 hold req: each is timed out after 4 cycles
      #2;
      rstn = 1'b0;
      tick();
      rstn = 1'b1;
      bus.req = 4'b1010;
      push(4'b0010, 2'd1, 1'b0, 1);
      push(4'b1000, 2'd3, 1'b1, 5);
      push(4'b1000, 2'd3, 1'b0, 6);
      push(4'b0000, 2'd0, 1'b1, 9);
      push(4'b0000, 2'd0, 1'b0, 10);
      repeat (14) tick();
      // client 1 drops then re-raises: eligible again; client 3 still blocked
      bus.req = 4'b1000; tick();
      bus.req = 4'b1010; push(4'b0010, 2'd1, 1'b0, 1); tick(); tick();
      bus.req = 4'b0000; push(4'b0000, 2'd0, 1'b0, 1); tick(); tick();
`endif

      repeat (3) tick();
      chk("pending_events", 32'(q.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
